pattern_gen_tx: RTL and testbench
=================================

// Module: pattern_gen_tx
// PURPOSE
//  Serial pattern transmitter: the driving end of the data/trig bit interface consumed by the pattern detector.
//  Accepts a PAT_W-bit word over a valid/ready handshake, shifts it out MSB first on 'data'.
//  Each bit occupies a programmable slot of bit_period clocks; a 1-cycle 'trig' strobe marks the sample point.
//  Used as the stimulus source and loopback partner of the detector, and as a standalone sequence generator.
// PARAMETERS
//  PAT_W  5  pattern word width = bits per frame (>=1)
//  DIV_W  8  width of bit_period slot-length field
// PORTS
//  clk         in   1      single system clock, all logic on rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  pat_valid   in   1      pat_data/bit_period valid
//  pat_ready   out  1      transmitter can accept a frame
//  pat_data    in   PAT_W  pattern; bit PAT_W-1 is sent first
//  bit_period  in   DIV_W  clocks per bit slot; 0 is treated as 1
//  abort       in   1      synchronous frame abort
//  data        out  1      serial bit, stable across its whole slot
//  trig        out  1      1-cycle sample strobe, last cycle of each slot
//  busy        out  1      frame in progress
//  done        out  1      1-cycle pulse after the last bit's trig
// BEHAVIOUR
//  - Reset (reset_n=0, async): state IDLE; data=0, trig=0, busy=0, done=0, pat_ready=1; shift reg and counters cleared.
//  - FSM: IDLE -> SHIFT on accept; SHIFT -> FIN after last bit's trig cycle; FIN -> IDLE, or -> SHIFT on accept.
//    abort in SHIFT -> IDLE.
//  - Accept: pat_valid & pat_ready sampled at a rising edge (edge E). pat_data and bit_period are latched at E.
//    P = max(bit_period,1). Later input changes are ignored until the next accept.
//  - pat_ready=1 in IDLE and FIN, 0 in SHIFT. busy=1 exactly while in SHIFT.
//  - Timing, cycle n = n-th cycle after E, bit k = 0..PAT_W-1, MSB first:
//    data = pat_data[PAT_W-1-k] during cycles k*P+1 .. (k+1)*P.
//    trig = 1 only at cycle (k+1)*P.
//    busy = 1 for cycles 1 .. PAT_W*P.
//    done = 1 at cycle PAT_W*P+1 only (state FIN), with pat_ready=1.
//  - Outside SHIFT, data=0 and trig=0. All outputs are registered; no combinational path from inputs to outputs.
//  - Slot counter counts P-1 down to 0. trig is asserted at count 0, where the counter reloads and the shift register advances.
//    Bit index runs PAT_W-1 down to 0.
//  - Back-to-back: accept in the FIN cycle starts a new frame. Its cycle 1 follows immediately, so there is no idle gap beyond FIN.
//  - P=1: trig is high every cycle of the frame, and data changes every cycle.
//  - abort=1 in SHIFT: at the next edge go to IDLE, data=0, trig=0, busy=0. No done pulse; pat_ready=1.
//    If abort coincides with the last trig cycle, abort wins: the trig cycle itself is still driven, but there is no done.
//  - abort is ignored in IDLE/FIN, and abort has priority over a simultaneous accept in FIN (the frame is not accepted).
//  - reset_n asserted mid-frame: immediate return to the reset values. The partial frame is discarded and no done is issued.
// TESTING
//  1. pat=5'b11010, P=1 -> data 1,1,0,1,0 on cycles 1-5; trig high cycles 1-5; done at cycle 6; busy cycles 1-5.
//  2. pat=5'b11010, P=3 -> trig only at cycles 3,6,9,12,15; data constant within slots; done at cycle 16.
//  3. Loopback into the detector with test 1 stimulus -> detector led reaches 5'b11111 after the 5th trig.
//     pat=5'b10010 -> led never reaches 5'b11111.
//  4. pat_valid held high, pat=5'b10101 then 5'b01011, P=2 -> second frame accepted at the done cycle.
//     Its first trig comes 2 cycles later; pat_ready=0 throughout both SHIFT phases.
//  5. bit_period=0 behaves exactly as P=1. Changing bit_period/pat_data mid-frame has no effect on the current frame.
//  6. P=3, abort at cycle 7 -> trig/data/busy=0 from cycle 8, no done, pat_ready=1.
//     Repeat with reset_n pulsed low at cycle 5: all outputs are at reset values asynchronously.

Source files
------------

// File: rtl/pattern_gen_tx.sv
// rtl/pattern_gen_tx.sv - serial pattern transmitter, MSB first, programmable bit slot with trig strobe
// Frames are latched on a valid/ready handshake and shifted out one bit per bit_period-clock slot.
module pattern_gen_tx #(
  parameter int PAT_W = 5,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [DIV_W-1:0] bit_period,
  input  logic             abort,
  output logic             data,
  output logic             trig,
  output logic             busy,
  output logic             done
);

  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [DIV_W-1:0] ONE  = 1;
  localparam logic [BW-1:0]    BONE = 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             data_q, data_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic [PAT_W-1:0] shifted;
  logic [DIV_W-1:0] pm1;

  assign pat_ready = ready_q;
  assign data      = data_q;
  assign trig      = trig_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Abort in FIN blocks a new frame; in IDLE it is simply ignored.
  assign accept  = pat_valid & ready_q & ~(abort & (state_q == FIN));
  assign shifted = shreg_q << 1;
  assign pm1     = (bit_period == '0) ? '0 : bit_period - ONE;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    bit_d   = bit_q;
    data_d  = data_q;
    trig_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;

    case (state_q)
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          data_d  = 1'b0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else if (cnt_q == '0) begin
          if (bit_q == '0) begin
            state_d = FIN;
            data_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            bit_d   = bit_q - BONE;
            shreg_d = shifted;
            data_d  = shifted[PAT_W-1];
            cnt_d   = per_q;
            trig_d  = (per_q == '0);
          end
        end else begin
          cnt_d  = cnt_q - ONE;
          trig_d = (cnt_q == ONE);
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (accept) begin
          state_d = SHIFT;
          shreg_d = pat_data;
          per_d   = pm1;
          cnt_d   = pm1;
          bit_d   = BW'(PAT_W - 1);
          data_d  = pat_data[PAT_W-1];
          trig_d  = (pm1 == '0);
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      bit_q   <= '0;
      data_q  <= 1'b0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_pattern_gen_tx.sv
// tb/tb_pattern_gen_tx.sv - directed self-checking bench for pattern_gen_tx
// Inputs are driven and outputs sampled on the falling edge; cycle n is the n-th rising edge after accept.
module tb_pattern_gen_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pat_valid;
  logic       pat_ready;
  logic [4:0] pat_data;
  logic [7:0] bit_period;
  logic       abort;
  logic       data;
  logic       trig;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pattern_gen_tx #(.PAT_W(5), .DIV_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pat_valid  (pat_valid),
    .pat_ready  (pat_ready),
    .pat_data   (pat_data),
    .bit_period (bit_period),
    .abort      (abort),
    .data       (data),
    .trig       (trig),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".data"},  data,      1'b0);
    chk({tag, ".trig"},  trig,      1'b0);
    chk({tag, ".busy"},  busy,      1'b0);
    chk({tag, ".done"},  done,      1'b0);
    chk({tag, ".ready"}, pat_ready, 1'b1);
  endtask

  // Expected outputs at cycle n of a 5-bit frame with slot length p.
  task automatic chk_cycle(input string tag, input logic [4:0] pat, input int p, input int n);
    logic [4:0] pv;
    logic in_frame;
    string t;
    pv = pat;
    in_frame = (n >= 1) && (n <= 5 * p);
    t = $sformatf("%s.c%0d", tag, n);
    chk({t, ".data"},  data,      in_frame ? pv[4 - (n - 1) / p] : 1'b0);
    chk({t, ".trig"},  trig,      in_frame && (n % p == 0));
    chk({t, ".busy"},  busy,      in_frame);
    chk({t, ".done"},  done,      n == 5 * p + 1);
    chk({t, ".ready"}, pat_ready, !in_frame);
  endtask

  // Accept at the next rising edge, then check cycles 1..5p+2 while scrambling inputs.
  task automatic run_frame(input string tag, input logic [4:0] pat, input logic [7:0] bp, input int p);
    @(negedge clk);
    pat_valid  = 1'b1;
    pat_data   = pat;
    bit_period = bp;
    for (int n = 1; n <= 5 * p + 2; n++) begin
      @(negedge clk);
      chk_cycle(tag, pat, p, n);
      if (n == 1) begin
        pat_valid  = 1'b0;
        pat_data   = ~pat;
        bit_period = bp + 8'd4;
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    pat_valid  = 1'b0;
    pat_data   = '0;
    bit_period = '0;
    abort      = 1'b0;
    #12;
    chk_idle("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    run_frame("p1",   5'b11010, 8'd1, 1);
    run_frame("p3",   5'b11010, 8'd3, 3);
    run_frame("p2",   5'b10010, 8'd2, 2);
    run_frame("bp0",  5'b11010, 8'd0, 1);
    run_frame("bp0b", 5'b01101, 8'd0, 1);

    // Back-to-back with pat_valid held high.
    @(negedge clk);
    pat_valid  = 1'b1;
    pat_data   = 5'b10101;
    bit_period = 8'd2;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      chk_cycle("b2b1", 5'b10101, 2, n);
      if (n == 1) pat_data = 5'b01011;
    end
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      chk_cycle("b2b2", 5'b01011, 2, n);
      if (n == 1) pat_valid = 1'b0;
    end

    // Abort at cycle 7 of a P=3 frame.
    @(negedge clk);
    pat_valid  = 1'b1;
    pat_data   = 5'b11010;
    bit_period = 8'd3;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      chk_cycle("abort", 5'b11010, 3, n);
      if (n == 1) pat_valid = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abort.c8");
    for (int n = 9; n <= 18; n++) begin
      @(negedge clk);
      chk_idle($sformatf("abort.c%0d", n));
    end

    // Abort in FIN blocks a simultaneous accept.
    @(negedge clk);
    pat_valid  = 1'b1;
    pat_data   = 5'b11111;
    bit_period = 8'd1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      chk_cycle("finab", 5'b11111, 1, n);
    end
    abort = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    pat_valid = 1'b0;
    chk_idle("finab.c7");
    @(negedge clk);
    chk_idle("finab.c8");

    // Asynchronous reset at cycle 5 of a P=3 frame.
    @(negedge clk);
    pat_valid  = 1'b1;
    pat_data   = 5'b11010;
    bit_period = 8'd3;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      chk_cycle("rst", 5'b11010, 3, n);
      if (n == 1) pat_valid = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    chk_idle("rst.async");
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      chk_idle($sformatf("rst.after%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
